// File: rtl/k423_if_bpu_upd_ctrl.sv
// Branch-predictor update scheduler: queues resolved EX outcomes, precomputes the
// new 2-bit PHT counter, and drains one update per cycle around fetch lookups.
`ifndef CORE_ADDR_W
`define CORE_ADDR_W 32
`endif

module k423_if_bpu_upd_ctrl #(
   parameter int UPD_DEPTH = 4,
   parameter int MAX_DEFER = 3,
   parameter int ADDR_W    = `CORE_ADDR_W
) (
   input  logic              clk_i,
   input  logic              rst_n_i,
   input  logic              ex_upd_vld_i,
   output logic              ex_upd_rdy_o,
   input  logic              ex_upd_tkn_i,
   input  logic [ADDR_W-1:0] ex_upd_pc_i,
   input  logic [1:0]        ex_upd_sat_cnt_i,
   input  logic              prd_act_i,
   input  logic              flush_i,
   output logic              upd_vld_o,
   output logic              upd_tkn_o,
   output logic [ADDR_W-1:0] upd_src_pc_o,
   output logic [1:0]        upd_sat_cnt_o,
   output logic              busy_o
);

   localparam int PTR_W = (UPD_DEPTH > 1) ? $clog2(UPD_DEPTH) : 1;
   localparam int DEF_W = $clog2(MAX_DEFER + 1) > 0 ? $clog2(MAX_DEFER + 1) : 1;
   localparam logic [DEF_W-1:0] MAX_DEF_C = DEF_W'(MAX_DEFER);
   localparam logic [PTR_W:0]   DEPTH_C   = (PTR_W + 1)'(UPD_DEPTH);

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_HOLD = 1'b1
   } state_t;

   state_t           state_reg, state_next;
   logic [PTR_W:0]   wr_ptr_reg, wr_ptr_next;
   logic [PTR_W:0]   rd_ptr_reg, rd_ptr_next;
   logic [DEF_W-1:0] defer_cnt_reg, defer_cnt_next;

   logic [ADDR_W-1:0] pc_mem  [UPD_DEPTH];
   logic              tkn_mem [UPD_DEPTH];
   logic [1:0]        cnt_mem [UPD_DEPTH];

   logic [PTR_W:0]   count;
   logic             empty;
   logic             full;
   logic [PTR_W-1:0] wr_idx;
   logic [PTR_W-1:0] rd_idx;
   logic [PTR_W-1:0] yng_idx;
   logic             enq;
   logic             drain;
   logic [1:0]       base_cnt;
   logic [1:0]       new_cnt;

   assign count   = wr_ptr_reg - rd_ptr_reg;
   assign empty   = (wr_ptr_reg == rd_ptr_reg);
   assign full    = (count == DEPTH_C);
   assign wr_idx  = wr_ptr_reg[PTR_W-1:0];
   assign rd_idx  = rd_ptr_reg[PTR_W-1:0];
   assign yng_idx = wr_idx - PTR_W'(1);

   assign ex_upd_rdy_o = !full && !flush_i;
   assign enq          = ex_upd_vld_i && ex_upd_rdy_o;

   // Same-PC chaining: a back-to-back update must build on the counter still in flight.
   always_comb begin
      base_cnt = ex_upd_sat_cnt_i;
      if (!empty && (pc_mem[yng_idx] == ex_upd_pc_i)) begin
         base_cnt = cnt_mem[yng_idx];
      end
   end

   always_comb begin
      new_cnt = base_cnt;
      if (ex_upd_tkn_i) begin
         if (base_cnt != 2'b11) new_cnt = base_cnt + 2'b01;
      end else begin
         if (base_cnt != 2'b00) new_cnt = base_cnt - 2'b01;
      end
   end

   assign drain = (state_reg == ST_HOLD) && !flush_i &&
                  (!prd_act_i || (defer_cnt_reg == MAX_DEF_C) || full);

   always_comb begin
      upd_vld_o     = drain;
      upd_tkn_o     = 1'b0;
      upd_src_pc_o  = '0;
      upd_sat_cnt_o = 2'b00;
      if (drain) begin
         upd_tkn_o     = tkn_mem[rd_idx];
         upd_src_pc_o  = pc_mem[rd_idx];
         upd_sat_cnt_o = cnt_mem[rd_idx];
      end
   end

   assign busy_o = (state_reg == ST_HOLD);

   always_comb begin
      state_next     = state_reg;
      wr_ptr_next    = wr_ptr_reg;
      rd_ptr_next    = rd_ptr_reg;
      defer_cnt_next = defer_cnt_reg;
      if (flush_i) begin
         state_next     = ST_IDLE;
         wr_ptr_next    = '0;
         rd_ptr_next    = '0;
         defer_cnt_next = '0;
      end else begin
         if (enq) wr_ptr_next = wr_ptr_reg + (PTR_W + 1)'(1);
         if (drain) rd_ptr_next = rd_ptr_reg + (PTR_W + 1)'(1);
         case (state_reg)
            ST_IDLE: begin
               defer_cnt_next = '0;
               if (enq) state_next = ST_HOLD;
            end
            ST_HOLD: begin
               if (drain) begin
                  defer_cnt_next = '0;
                  if ((count == (PTR_W + 1)'(1)) && !enq) state_next = ST_IDLE;
               end else if (defer_cnt_reg != MAX_DEF_C) begin
                  defer_cnt_next = defer_cnt_reg + DEF_W'(1);
               end
            end
            default: state_next = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_reg     <= ST_IDLE;
         wr_ptr_reg    <= '0;
         rd_ptr_reg    <= '0;
         defer_cnt_reg <= '0;
      end else begin
         state_reg     <= state_next;
         wr_ptr_reg    <= wr_ptr_next;
         rd_ptr_reg    <= rd_ptr_next;
         defer_cnt_reg <= defer_cnt_next;
      end
   end

   // Payload is never read before being written, so it carries no reset.
   always_ff @(posedge clk_i) begin
      if (enq) begin
         pc_mem[wr_idx]  <= ex_upd_pc_i;
         tkn_mem[wr_idx] <= ex_upd_tkn_i;
         cnt_mem[wr_idx] <= new_cnt;
      end
   end

endmodule

// File: tb/tb_k423_if_bpu_upd_ctrl.sv
// Directed bench for the BPU update scheduler: counter math, chaining, deferral,
// full-queue behaviour, flush and asynchronous reset.
`timescale 1ns/1ps

module tb_k423_if_bpu_upd_ctrl;

   logic        clk_i = 1'b0;
   logic        rst_n_i;
   logic        ex_upd_vld_i;
   logic        ex_upd_rdy_o;
   logic        ex_upd_tkn_i;
   logic [31:0] ex_upd_pc_i;
   logic [1:0]  ex_upd_sat_cnt_i;
   logic        prd_act_i;
   logic        flush_i;
   logic        upd_vld_o;
   logic        upd_tkn_o;
   logic [31:0] upd_src_pc_o;
   logic [1:0]  upd_sat_cnt_o;
   logic        busy_o;

   int errs   = 0;
   int checks = 0;

   k423_if_bpu_upd_ctrl #(
      .UPD_DEPTH(4),
      .MAX_DEFER(3),
      .ADDR_W(32)
   ) dut (
      .clk_i           (clk_i),
      .rst_n_i         (rst_n_i),
      .ex_upd_vld_i    (ex_upd_vld_i),
      .ex_upd_rdy_o    (ex_upd_rdy_o),
      .ex_upd_tkn_i    (ex_upd_tkn_i),
      .ex_upd_pc_i     (ex_upd_pc_i),
      .ex_upd_sat_cnt_i(ex_upd_sat_cnt_i),
      .prd_act_i       (prd_act_i),
      .flush_i         (flush_i),
      .upd_vld_o       (upd_vld_o),
      .upd_tkn_o       (upd_tkn_o),
      .upd_src_pc_o    (upd_src_pc_o),
      .upd_sat_cnt_o   (upd_sat_cnt_o),
      .busy_o          (busy_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Apply inputs just after a clock edge, then let combinational outputs settle.
   task automatic drive(input logic vld, input logic tkn, input logic [31:0] pc,
                        input logic [1:0] sat, input logic prd, input logic fl);
      ex_upd_vld_i     = vld;
      ex_upd_tkn_i     = tkn;
      ex_upd_pc_i      = pc;
      ex_upd_sat_cnt_i = sat;
      prd_act_i        = prd;
      flush_i          = fl;
      #1;
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic expect_upd(input string tag, input logic [31:0] pc,
                             input logic tkn, input logic [1:0] cnt);
      chk({tag, "_vld"}, {31'd0, upd_vld_o}, 32'd1);
      chk({tag, "_pc"},  upd_src_pc_o, pc);
      chk({tag, "_tkn"}, {31'd0, upd_tkn_o}, {31'd0, tkn});
      chk({tag, "_cnt"}, {30'd0, upd_sat_cnt_o}, {30'd0, cnt});
      $display("drain %s pc=%0h tkn=%0b cnt=%0b", tag, upd_src_pc_o, upd_tkn_o, upd_sat_cnt_o);
   endtask

   task automatic expect_idle_out(input string tag);
      chk({tag, "_vld0"}, {31'd0, upd_vld_o}, 32'd0);
      chk({tag, "_pc0"},  upd_src_pc_o, 32'd0);
      chk({tag, "_cnt0"}, {30'd0, upd_sat_cnt_o}, 32'd0);
   endtask

   // One isolated update through an empty queue with no fetch contention.
   task automatic single(input string tag, input logic [31:0] pc, input logic tkn,
                         input logic [1:0] sat, input logic [1:0] exp_cnt);
      drive(1'b1, tkn, pc, sat, 1'b0, 1'b0);
      chk({tag, "_rdy"}, {31'd0, ex_upd_rdy_o}, 32'd1);
      chk({tag, "_novld"}, {31'd0, upd_vld_o}, 32'd0);
      tick();
      drive(1'b0, 1'b0, 32'd0, 2'b00, 1'b0, 1'b0);
      expect_upd(tag, pc, tkn, exp_cnt);
      chk({tag, "_busy"}, {31'd0, busy_o}, 32'd1);
      tick();
      drive(1'b0, 1'b0, 32'd0, 2'b00, 1'b0, 1'b0);
      chk({tag, "_busy0"}, {31'd0, busy_o}, 32'd0);
      expect_idle_out(tag);
   endtask

   initial begin
      rst_n_i = 1'b0;
      drive(1'b0, 1'b0, 32'd0, 2'b00, 1'b0, 1'b0);
      tick();
      tick();
      chk("rst_vld",  {31'd0, upd_vld_o}, 32'd0);
      chk("rst_busy", {31'd0, busy_o}, 32'd0);
      chk("rst_rdy",  {31'd0, ex_upd_rdy_o}, 32'd1);
      chk("rst_pc",   upd_src_pc_o, 32'd0);
      rst_n_i = 1'b1;
      tick();

      single("single",  32'h100, 1'b1, 2'b01, 2'b10);
      single("sat_t11", 32'h110, 1'b1, 2'b11, 2'b11);
      single("sat_n00", 32'h120, 1'b0, 2'b00, 2'b00);
      single("sat_n10", 32'h130, 1'b0, 2'b10, 2'b01);

      // Same-PC chaining while fetch holds the lookup port.
      drive(1'b1, 1'b1, 32'h200, 2'b00, 1'b1, 1'b0);
      tick();
      drive(1'b1, 1'b1, 32'h200, 2'b00, 1'b1, 1'b0);
      chk("chain_defer", {31'd0, upd_vld_o}, 32'd0);
      tick();
      drive(1'b0, 1'b0, 32'd0, 2'b00, 1'b0, 1'b0);
      expect_upd("chain0", 32'h200, 1'b1, 2'b01);
      tick();
      expect_upd("chain1", 32'h200, 1'b1, 2'b10);
      tick();
      chk("chain_busy0", {31'd0, busy_o}, 32'd0);

      // Bounded deferral: three deferred cycles, drained on the fourth.
      drive(1'b1, 1'b0, 32'h300, 2'b11, 1'b1, 1'b0);
      tick();
      drive(1'b0, 1'b0, 32'd0, 2'b00, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("defer_%0d", i), {31'd0, upd_vld_o}, 32'd0);
         tick();
      end
      expect_upd("defer_pop", 32'h300, 1'b0, 2'b10);
      tick();
      chk("defer_busy0", {31'd0, busy_o}, 32'd0);
      drive(1'b1, 1'b1, 32'h304, 2'b01, 1'b1, 1'b0);
      tick();
      drive(1'b0, 1'b0, 32'd0, 2'b00, 1'b1, 1'b0);
      chk("defer_clr", {31'd0, upd_vld_o}, 32'd0);
      drive(1'b0, 1'b0, 32'd0, 2'b00, 1'b0, 1'b0);
      expect_upd("defer_2nd", 32'h304, 1'b1, 2'b10);
      tick();

      // Fill the queue under continuous prediction activity.
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 1'b0, 32'h400 + 32'(4 * i), 2'b10, 1'b1, 1'b0);
         chk($sformatf("full_rdy_%0d", i), {31'd0, ex_upd_rdy_o}, 32'd1);
         chk($sformatf("full_hold_%0d", i), {31'd0, upd_vld_o}, 32'd0);
         tick();
      end
      drive(1'b1, 1'b1, 32'h410, 2'b00, 1'b1, 1'b0);
      chk("full_rdy0", {31'd0, ex_upd_rdy_o}, 32'd0);
      expect_upd("full_force", 32'h400, 1'b0, 2'b01);
      tick();
      drive(1'b0, 1'b0, 32'd0, 2'b00, 1'b1, 1'b0);
      chk("full_rdy1", {31'd0, ex_upd_rdy_o}, 32'd1);
      chk("full_after", {31'd0, upd_vld_o}, 32'd0);
      drive(1'b0, 1'b0, 32'd0, 2'b00, 1'b0, 1'b0);
      for (int i = 1; i < 4; i++) begin
         expect_upd($sformatf("full_d%0d", i), 32'h400 + 32'(4 * i), 1'b0, 2'b01);
         tick();
      end
      chk("full_busy0", {31'd0, busy_o}, 32'd0);
      chk("full_nodrop", {31'd0, upd_vld_o}, 32'd0);

      // Flush with a concurrent valid: nothing drains, new update dropped.
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 1'b1, 32'h500 + 32'(4 * i), 2'b01, 1'b1, 1'b0);
         tick();
      end
      drive(1'b1, 1'b1, 32'h50c, 2'b01, 1'b0, 1'b1);
      chk("flush_rdy0", {31'd0, ex_upd_rdy_o}, 32'd0);
      expect_idle_out("flush");
      tick();
      drive(1'b0, 1'b0, 32'd0, 2'b00, 1'b0, 1'b0);
      chk("flush_busy0", {31'd0, busy_o}, 32'd0);
      chk("flush_vld0", {31'd0, upd_vld_o}, 32'd0);
      tick();
      chk("flush_drop", {31'd0, upd_vld_o}, 32'd0);
      $display("flush done busy=%0b", busy_o);

      // Asynchronous reset in the middle of a drain.
      drive(1'b1, 1'b0, 32'h600, 2'b01, 1'b1, 1'b0);
      tick();
      drive(1'b1, 1'b0, 32'h604, 2'b01, 1'b1, 1'b0);
      tick();
      drive(1'b0, 1'b0, 32'd0, 2'b00, 1'b0, 1'b0);
      expect_upd("rst_mid", 32'h600, 1'b0, 2'b00);
      rst_n_i = 1'b0;
      #1;
      chk("arst_busy", {31'd0, busy_o}, 32'd0);
      chk("arst_rdy",  {31'd0, ex_upd_rdy_o}, 32'd1);
      expect_idle_out("arst");
      tick();
      rst_n_i = 1'b1;
      tick();
      chk("arst_after", {31'd0, busy_o}, 32'd0);

      single("post_rst", 32'h700, 1'b1, 2'b10, 2'b11);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/k423_if_bpu_upd_ctrl.md
Name: k423_if_bpu_upd_ctrl

Overview:
- Update scheduler for the branch history/pattern tables in the IF-stage BPU.
- Accepts resolved-branch outcomes from EX via a valid/ready handshake and buffers them in a small in-order queue.
- Computes the next 2-bit saturating counter for each outcome and issues at most one table update per cycle.
- Defers updates while fetch is using the predict lookup, with a bounded-age override so updates cannot starve.

Parameters:
- UPD_DEPTH, 4: queue entries; power of two, ≥2.
- MAX_DEFER, 3: maximum consecutive cycles the head entry may be deferred by prd_act_i.
- ADDR_W, `CORE_ADDR_W: PC width.

Ports:
- clk_i  in  1  clock.
- rst_n_i  in  1  asynchronous active-low reset.
- ex_upd_vld_i  in  1  EX presents a resolved conditional branch.
- ex_upd_rdy_o  out  1  queue can accept this cycle.
- ex_upd_tkn_i  in  1  actual branch direction.
- ex_upd_pc_i  in  ADDR_W  branch PC.
- ex_upd_sat_cnt_i  in  2  counter value read at prediction time.
- prd_act_i  in  1  fetch is performing a predict lookup this cycle.
- flush_i  in  1  discard all queued updates (predictor disable / context switch).
- upd_vld_o  out  1  table write strobe.
- upd_tkn_o  out  1  direction, shifted into the BHR.
- upd_src_pc_o  out  ADDR_W  PC used to index the tables.
- upd_sat_cnt_o  out  2  new PHT counter value.
- busy_o  out  1  queue non-empty.

Behaviour:
- Counter encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
  - Taken: next = min(base+1, 3). Not taken: next = max(base-1, 0).
  - Saturating; never wraps.
- Base selection at enqueue:
  - If the queue is non-empty and the youngest queued entry's PC equals ex_upd_pc_i, base = that entry's stored counter (same-PC chaining).
  - Otherwise base = ex_upd_sat_cnt_i.
- The entry stores {pc, tkn, next}, computed at enqueue.
- Queue: circular, pointers one bit wider than log2(UPD_DEPTH).
  - ex_upd_rdy_o = !full. There is no enqueue-while-full, even when a dequeue happens in the same cycle.
  - Enqueue occurs when ex_upd_vld_i && ex_upd_rdy_o.
  - An entry enqueued in cycle N is eligible for drain from cycle N+1; there is no empty bypass.
- FSM:
  - IDLE: queue empty. Go to HOLD on enqueue.
  - HOLD: queue non-empty. Drain condition = !prd_act_i || defer_cnt == MAX_DEFER || full.
    - When the condition is met, upd_vld_o = 1 that cycle, outputs show the head entry combinationally, and the head pops.
    - Return to IDLE when the pop empties the queue and there is no simultaneous enqueue.
- defer_cnt:
  - Cleared on every pop and in IDLE.
  - Incremented (saturating at MAX_DEFER) each HOLD cycle where the head is not drained.
- Simultaneous enqueue and dequeue: both take effect; count unchanged. The chaining compare uses the youngest entry even if it is the head being popped.
- flush_i:
  - Highest priority. Next cycle the queue is empty, state is IDLE, and defer_cnt is 0.
  - upd_vld_o is forced 0 in the flush cycle.
  - Any enqueue in the flush cycle is dropped, and ex_upd_rdy_o is 0 while flush_i = 1.
- Reset (async, any time): pointers, count, defer_cnt and state are cleared.
  - Outputs: upd_vld_o = 0, busy_o = 0, ex_upd_rdy_o = 1 (while not flushing), upd_* data = 0.
  - Queue payload does not need reset.
- When upd_vld_o = 0, upd_* data outputs are 0.
- Order is strictly FIFO; no entry is dropped except by flush/reset.

Test Plan:
- Single update: PC=0x100, tkn=1, sat_cnt=01, prd_act_i=0 → next cycle upd_vld_o=1, pc=0x100, tkn=1, sat_cnt=10; busy_o falls the cycle after.
- Saturation: tkn=1 with sat 11 → 11; tkn=0 with sat 00 → 00; tkn=0 with sat 10 → 01.
- Chaining: back-to-back PC=0x200, tkn=1, both sat_cnt=00, prd_act_i held 1 → drained counters 01 then 10, in order.
- Deferral: 1 entry queued, prd_act_i held 1 → exactly MAX_DEFER=3 deferred cycles, then drained on the 4th; defer_cnt resets after the pop.
- Full: 4 enqueues with prd_act_i=1 → ex_upd_rdy_o=0 after the 4th; drain is forced every cycle while full; rdy returns to 1 the cycle after the first pop.
- Flush/reset: 3 entries queued, then flush_i=1 together with a new valid → no upd_vld_o, the new update is dropped, busy_o=0 next cycle. Repeat with rst_n_i asserted mid-drain → outputs go to reset values immediately.
